// File: rtl/apb2axi_rdata_drain_arbiter.sv
`default_nettype none
// ============================================================================
// apb2axi_rdata_drain_arbiter : round-robin lock-and-drain arbiter sharing one
// APB read-data drain port among the per-TAG read-word streams.
// Revision 1.0
// ============================================================================
module apb2axi_rdata_drain_arbiter #(
   parameter int TAG_NUM    = 8,
   parameter int APB_DATA_W = 32,
   parameter int MAX_WORDS  = 64,
   localparam int TAG_W     = $clog2(TAG_NUM),
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [TAG_NUM-1:0]            tag_en,
   input  logic [TAG_NUM-1:0]            rdf_reg_data_vld,
   input  logic [TAG_NUM*APB_DATA_W-1:0] rdf_reg_data_out,
   input  logic [TAG_NUM-1:0]            rdf_reg_data_last,
   output logic [TAG_NUM-1:0]            rdf_reg_data_rdy,
   output logic                          drn_vld,
   output logic [APB_DATA_W-1:0]         drn_data,
   output logic [TAG_W-1:0]              drn_tag,
   output logic                          drn_last,
   input  logic                          drn_rdy,
   output logic                          drn_done_vld,
   output logic [TAG_W-1:0]              drn_done_tag,
   output logic [CNT_W-1:0]              drn_done_words,
   output logic                          drn_done_err
);

   localparam logic [0:0]       c_IDLE      = 1'b0;
   localparam logic [0:0]       c_LOCK      = 1'b1;
   localparam logic [TAG_W:0]   c_TAG_NUM   = (TAG_W+1)'(TAG_NUM);
   localparam logic [CNT_W-1:0] c_MAX_WORDS = CNT_W'(MAX_WORDS);

   logic [0:0]            r_state;
   logic [TAG_W-1:0]      r_gnt;
   logic [TAG_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_word_cnt;
   logic                  r_done_vld;
   logic [TAG_W-1:0]      r_done_tag;
   logic [CNT_W-1:0]      r_done_words;
   logic                  r_done_err;

   logic [TAG_NUM-1:0]    w_elig;
   logic                  w_any;
   logic [TAG_W-1:0]      w_pick;
   logic [TAG_W:0]        w_cand;
   logic                  w_lock;
   logic                  w_hs;
   logic                  w_release;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [APB_DATA_W-1:0] w_words [TAG_NUM];

   for (genvar g = 0; g < TAG_NUM; g++) begin : g_unpack
      assign w_words[g] = rdf_reg_data_out[g*APB_DATA_W +: APB_DATA_W];
   end

   assign w_elig = rdf_reg_data_vld & tag_en;

   // Search starts one past the last owner and wraps, so the last owner ranks lowest.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int i = 1; i <= TAG_NUM; i++) begin
         w_cand = {1'b0, r_rr_ptr} + (TAG_W+1)'(i);
         if (w_cand >= c_TAG_NUM) begin
            w_cand = w_cand - c_TAG_NUM;
         end
         if (!w_any && w_elig[w_cand[TAG_W-1:0]]) begin
            w_any  = 1'b1;
            w_pick = w_cand[TAG_W-1:0];
         end
      end
   end

   assign w_lock   = (r_state == c_LOCK);
   assign drn_vld  = w_lock && rdf_reg_data_vld[r_gnt];
   assign drn_data = w_lock ? w_words[r_gnt] : '0;
   assign drn_last = w_lock && rdf_reg_data_last[r_gnt];
   assign drn_tag  = w_lock ? r_gnt : '0;

   for (genvar g = 0; g < TAG_NUM; g++) begin : g_rdy
      assign rdf_reg_data_rdy[g] = w_lock && drn_rdy && (r_gnt == TAG_W'(g));
   end

   assign w_hs      = drn_vld && drn_rdy;
   assign w_cnt_nxt = r_word_cnt + CNT_W'(1);
   // A genuine last word wins over the watchdog when both land on the same handshake.
   assign w_release = w_hs && (drn_last || (w_cnt_nxt == c_MAX_WORDS));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state      <= c_IDLE;
         r_gnt        <= '0;
         r_rr_ptr     <= TAG_W'(TAG_NUM - 1);
         r_word_cnt   <= '0;
         r_done_vld   <= 1'b0;
         r_done_tag   <= '0;
         r_done_words <= '0;
         r_done_err   <= 1'b0;
      end else begin
         r_done_vld <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_pick;
                  r_word_cnt <= '0;
                  r_state    <= c_LOCK;
               end
            end
            c_LOCK: begin
               if (w_hs) begin
                  r_word_cnt <= w_cnt_nxt;
               end
               if (w_release) begin
                  r_state      <= c_IDLE;
                  r_rr_ptr     <= r_gnt;
                  r_done_vld   <= 1'b1;
                  r_done_tag   <= r_gnt;
                  r_done_words <= w_cnt_nxt;
                  r_done_err   <= !drn_last;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign drn_done_vld   = r_done_vld;
   assign drn_done_tag   = r_done_tag;
   assign drn_done_words = r_done_words;
   assign drn_done_err   = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rdata_drain_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_apb2axi_rdata_drain_arbiter : bench for the round-robin read-data drain
// arbiter, with per-TAG word sources and a grant-level reference model.
// Revision 1.0
// ============================================================================
module tb_apb2axi_rdata_drain_arbiter;

   localparam int NT   = 8;
   localparam int DW   = 32;
   localparam int MAXW = 64;
   localparam int QD   = 1024;

   logic           pclk;
   logic           presetn;
   logic [NT-1:0]  tag_en;
   logic [NT-1:0]  rdf_reg_data_vld;
   logic [NT*DW-1:0] rdf_reg_data_out;
   logic [NT-1:0]  rdf_reg_data_last;
   logic [NT-1:0]  rdf_reg_data_rdy;
   logic           drn_vld;
   logic [DW-1:0]  drn_data;
   logic [2:0]     drn_tag;
   logic           drn_last;
   logic           drn_rdy;
   logic           drn_done_vld;
   logic [2:0]     drn_done_tag;
   logic [6:0]     drn_done_words;
   logic           drn_done_err;

   apb2axi_rdata_drain_arbiter #(
      .TAG_NUM   (NT),
      .APB_DATA_W(DW),
      .MAX_WORDS (MAXW)
   ) dut (
      .pclk             (pclk),
      .presetn          (presetn),
      .tag_en           (tag_en),
      .rdf_reg_data_vld (rdf_reg_data_vld),
      .rdf_reg_data_out (rdf_reg_data_out),
      .rdf_reg_data_last(rdf_reg_data_last),
      .rdf_reg_data_rdy (rdf_reg_data_rdy),
      .drn_vld          (drn_vld),
      .drn_data         (drn_data),
      .drn_tag          (drn_tag),
      .drn_last         (drn_last),
      .drn_rdy          (drn_rdy),
      .drn_done_vld     (drn_done_vld),
      .drn_done_tag     (drn_done_tag),
      .drn_done_words   (drn_done_words),
      .drn_done_err     (drn_done_err)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;

   // Per-TAG word sources: circular buffers of {last, data}
   logic [DW:0] mem [NT][QD];
   int          hd  [NT];
   int          cnt [NT];
   logic [NT-1:0] stall;

   // Reference model state: who owns the port, who owned it last, words so far
   bit m_locked;
   int m_gnt, m_ptr, m_cnt;
   bit m_dv, m_derr;
   int m_dtag, m_dwords;

   typedef struct {
      logic [NT-1:0] vld;
      logic [NT-1:0] en;
      int            tag;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int t, input logic [DW-1:0] d, input logic last);
      mem[t][(hd[t] + cnt[t]) % QD] = {last, d};
      cnt[t]++;
   endtask

   task automatic flush_all();
      for (int t = 0; t < NT; t++) cnt[t] = 0;
   endtask

   function automatic int total();
      int s = 0;
      for (int t = 0; t < NT; t++) s += cnt[t];
      return s;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_gnt = 0; m_ptr = NT - 1; m_cnt = 0;
      m_dv = 0; m_dtag = 0; m_dwords = 0; m_derr = 0;
   endtask

   task automatic drive_src();
      for (int t = 0; t < NT; t++) begin
         if (cnt[t] > 0) begin
            rdf_reg_data_vld[t]          = !stall[t];
            rdf_reg_data_out[t*DW +: DW] = mem[t][hd[t]][DW-1:0];
            rdf_reg_data_last[t]         = mem[t][hd[t]][DW];
         end else begin
            rdf_reg_data_vld[t]          = 1'b0;
            rdf_reg_data_out[t*DW +: DW] = '0;
            rdf_reg_data_last[t]         = 1'b0;
         end
      end
   endtask

   // One clock: drive sources, compare against the model mid-cycle, advance model, clock.
   task automatic cycle();
      bit found;
      bit lastw;
      int nt;
      logic [NT-1:0] exp_rdy;
      logic exp_vld;
      drive_src();
      #1;
      if (!presetn) model_reset();
      exp_vld = m_locked ? rdf_reg_data_vld[m_gnt] : 1'b0;
      exp_rdy = (m_locked && drn_rdy) ? (NT'(1) << m_gnt) : '0;
      check("drn_vld", drn_vld, exp_vld);
      check("rdy_vec", rdf_reg_data_rdy, exp_rdy);
      check("drn_data", drn_data, m_locked ? rdf_reg_data_out[m_gnt*DW +: DW] : 32'h0);
      check("drn_last", drn_last, m_locked ? rdf_reg_data_last[m_gnt] : 1'b0);
      if (exp_vld) check("drn_tag", drn_tag, m_gnt);
      check("done_vld", drn_done_vld, m_dv);
      check("done_tag", drn_done_tag, m_dtag);
      check("done_words", drn_done_words, m_dwords);
      check("done_err", drn_done_err, m_derr);
      if (presetn) begin
         m_dv = 0;
         if (m_locked) begin
            if (rdf_reg_data_vld[m_gnt] && drn_rdy) begin
               lastw = rdf_reg_data_last[m_gnt];
               hd[m_gnt] = (hd[m_gnt] + 1) % QD;
               cnt[m_gnt]--;
               m_cnt++;
               if (lastw || m_cnt == MAXW) begin
                  m_locked = 0; m_ptr = m_gnt;
                  m_dv = 1; m_dtag = m_gnt; m_dwords = m_cnt; m_derr = !lastw;
               end
            end
         end else begin
            found = 0;
            for (int k = 1; k <= NT; k++) begin
               nt = (m_ptr + k) % NT;
               if (!found && rdf_reg_data_vld[nt] && tag_en[nt]) begin
                  found = 1; m_gnt = nt;
               end
            end
            if (found) begin
               m_locked = 1; m_cnt = 0;
            end
         end
      end
      @(posedge pclk);
      #1;
      if (!presetn) model_reset();
   endtask

   task automatic wait_done(input int mx, input string nm, input int etag, input int ewords,
                            input int eerr, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (drn_done_vld !== 1'b1 && n < mx);
      check({nm, "_seen"}, drn_done_vld, 1'b1);
      check({nm, "_tag"}, drn_done_tag, etag);
      check({nm, "_words"}, drn_done_words, ewords);
      check({nm, "_err"}, drn_done_err, eerr);
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      stall   = '0;
      flush_all();
      repeat (3) cycle();
      presetn = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      tbl[0] = '{8'b0000_1110, 8'hff,        1};
      tbl[1] = '{8'b1000_0011, 8'hff,        7};
      tbl[2] = '{8'b0000_0011, 8'hff,        0};
      tbl[3] = '{8'b0000_0001, 8'hff,        0};
      tbl[4] = '{8'b0010_0100, 8'b1101_1111, 2};
      tbl[5] = '{8'b0000_0110, 8'b1111_1011, 1};
      tbl[6] = '{8'b1111_1111, 8'hff,        2};
      tbl[7] = '{8'b0000_0010, 8'hff,        1};

      presetn = 1'b0; drn_rdy = 1'b0; tag_en = '1; stall = '0;
      rdf_reg_data_vld = '0; rdf_reg_data_out = '0; rdf_reg_data_last = '0;
      for (int t = 0; t < NT; t++) begin hd[t] = 0; cnt[t] = 0; end
      model_reset();
      do_reset();

      // Arbitration order from a known pointer history, one single-word grant per row
      drn_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tag_en = tbl[i].en;
         for (int t = 0; t < NT; t++) if (tbl[i].vld[t]) push(t, $urandom, 1'b1);
         wait_done(20, $sformatf("tbl%0d", i), tbl[i].tag, 1, 0, n);
         flush_all();
         tag_en = '1;
      end

      // Single TAG 3 burst of four words
      for (int j = 0; j < 4; j++) push(3, 32'hA0 + j, j == 3);
      wait_done(20, "a_tag3", 3, 4, 0, n);
      check("a_latency", n, 5);

      // TAG 0 keeps requesting; TAG 5 arrives once TAG 0 holds the port
      push(0, $urandom, 0); push(0, $urandom, 1);
      push(0, $urandom, 0); push(0, $urandom, 1);
      cycle();
      push(5, $urandom, 1);
      wait_done(20, "f_t0a", 0, 2, 0, n);
      wait_done(20, "f_t5", 5, 1, 0, n);
      wait_done(20, "f_t0b", 0, 2, 0, n);

      // Stalls on TAG 2, then masking it mid-grant
      for (int j = 0; j < 6; j++) push(2, $urandom, j == 5);
      for (int i = 0; i < 8; i++) begin
         drn_rdy  = (i == 1 || i == 3) ? 1'b0 : 1'b1;
         stall[2] = (i >= 4 && i <= 6);
         if (i == 5) tag_en[2] = 1'b0;
         cycle();
      end
      stall = '0; drn_rdy = 1'b1;
      wait_done(20, "e_t2", 2, 6, 0, n);
      push(2, $urandom, 0); push(2, $urandom, 1); push(6, $urandom, 1);
      wait_done(20, "e_t6", 6, 1, 0, n);
      repeat (5) cycle();
      #1 check("e_masked_idle", drn_vld, 1'b0);
      tag_en = '1;
      wait_done(20, "e_t2b", 2, 2, 0, n);

      // Watchdog: 70 words, only the 70th flagged last
      for (int j = 0; j < 70; j++) push(1, $urandom, j == 69);
      wait_done(100, "c_wd", 1, 64, 1, n);
      wait_done(30, "c_rest", 1, 6, 0, n);

      // Three simultaneous requesters straight out of reset
      do_reset();
      for (int t = 0; t < 3; t++) begin push(t, $urandom, 0); push(t, $urandom, 1); end
      wait_done(20, "b_t0", 0, 2, 0, n); check("b_gap0", n, 3);
      wait_done(20, "b_t1", 1, 2, 0, n); check("b_gap1", n, 3);
      wait_done(20, "b_t2", 2, 2, 0, n); check("b_gap2", n, 3);

      // Reset in the middle of a TAG 4 grant after two handshakes
      for (int j = 0; j < 5; j++) push(4, $urandom, j == 4);
      repeat (3) cycle();
      push(0, $urandom, 1);
      presetn = 1'b0;
      #1;
      check("d_rst_vld", drn_vld, 1'b0);
      check("d_rst_rdy", rdf_reg_data_rdy, 8'h00);
      cycle(); cycle();
      presetn = 1'b1;
      wait_done(20, "d_t0", 0, 1, 0, n);
      wait_done(20, "d_t4", 4, 3, 0, n);

      // Randomized traffic against the model
      for (int i = 0; i < 2500; i++) begin
         int t, len;
         drn_rdy = ($urandom % 4) != 0;
         for (int k = 0; k < NT; k++) stall[k] = ($urandom % 5) == 0;
         tag_en = (($urandom % 3) == 0) ? NT'($urandom) : '1;
         if (($urandom % 6) == 0) begin
            t   = $urandom_range(0, NT - 1);
            len = $urandom_range(1, 4);
            if (cnt[t] < 900)
               for (int j = 0; j < len; j++) push(t, $urandom, (j == len - 1) && (($urandom % 8) != 0));
         end
         cycle();
      end
      stall = '0; tag_en = '1; drn_rdy = 1'b1;
      n = 0;
      while (total() > 0 && n < 3000) begin cycle(); n++; end
      check("drain_empty", total(), 0);
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb2axi_rdata_drain_arbiter.md
# apb2axi_rdata_drain_arbiter

Round-robin scheduler that shares a single APB read-data drain port among the per-TAG read-word streams produced by the response handler. It locks onto one TAG, forwards its APB words in order until the word flagged last has been consumed, then reports a completion record and re-arbitrates. It sits between the response handler's per-TAG drain outputs and the APB register block.

## Interface
Parameters:
- TAG_NUM, 8: number of TAGs, and so the number of requesters.
- APB_DATA_W, 32: width of one APB data word.
- MAX_WORDS, 64: watchdog limit on the words drained per grant.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset, asynchronous assertion, active-low.
- tag_en  in  TAG_NUM  per-TAG arbitration enable.
- rdf_reg_data_vld  in  TAG_NUM  per-TAG word valid.
- rdf_reg_data_out  in  TAG_NUM×APB_DATA_W  per-TAG word.
- rdf_reg_data_last  in  TAG_NUM  per-TAG final-word flag.
- rdf_reg_data_rdy  out  TAG_NUM  per-TAG pop; at most one bit set.
- drn_vld  out  1  drain word valid.
- drn_data  out  APB_DATA_W  drain word.
- drn_tag  out  $clog2(TAG_NUM)  TAG that owns drn_data.
- drn_last  out  1  final word of the granted TAG.
- drn_rdy  in  1  consumer accepts the word.
- drn_done_vld  out  1  one-cycle completion pulse.
- drn_done_tag  out  $clog2(TAG_NUM)  completed TAG.
- drn_done_words  out  $clog2(MAX_WORDS+1)  words drained in the grant.
- drn_done_err  out  1  watchdog release; the last word was never seen.

## Operation
- Requester t is eligible when rdf_reg_data_vld[t] && tag_en[t].
- State machine has two states, IDLE and LOCK.
- IDLE:
  - If any TAG is eligible, register gnt = the first eligible TAG, searching upward and wrapping from rr_ptr+1 modulo TAG_NUM.
  - Clear word_cnt to 0 and go to LOCK.
  - If no TAG is eligible, stay in IDLE.
- LOCK, combinational forwarding:
  - drn_vld = rdf_reg_data_vld[gnt]
  - drn_data = rdf_reg_data_out[gnt]
  - drn_last = rdf_reg_data_last[gnt]
  - drn_tag = gnt
  - rdf_reg_data_rdy[gnt] = drn_rdy; every other rdy bit is 0.
- Handshake: drn_vld && drn_rdy. Each handshake increments word_cnt.
- Release happens on either of these handshakes:
  - a handshake with drn_last = 1, which sets err = 0;
  - a handshake that makes word_cnt reach MAX_WORDS with drn_last = 0, which sets err = 1.
- On release:
  - go to IDLE and set rr_ptr = gnt;
  - on the next cycle, drive drn_done_vld = 1 with drn_done_tag = gnt, drn_done_words = the final word_cnt, and drn_done_err = err.
- Clearing tag_en[gnt] during LOCK has no effect; the grant holds until release. Masking only affects new arbitration.
- drn_vld may deassert mid-grant (the handler buffer runs empty); the lock holds and the block waits.
- In IDLE: drn_vld = 0, rdf_reg_data_rdy = 0, drn_data = 0, drn_last = 0.
- The drain port carries no other-TAG traffic until the current TAG releases; words are never reordered or duplicated.

## Timing
- Reset values, while presetn = 0:
  - state = IDLE; rr_ptr = TAG_NUM-1, so TAG 0 has first priority;
  - gnt = 0, word_cnt = 0;
  - all outputs 0.
- Reset asserted mid-LOCK aborts the grant immediately and emits no done pulse. Words already consumed are not restored.
- Grant latency: eligible in IDLE at cycle N → LOCK with drn_vld valid at cycle N+1.
- Back-to-back grants: release handshake at cycle N → IDLE at N+1 → next LOCK at N+2. Minimum gap is one idle cycle.
- drn_done_vld is a single cycle at N+1 after the release handshake at N. The done fields hold their values until the next pulse.
- drn_data, drn_last and rdf_reg_data_rdy are combinational from the inputs in LOCK, with zero added latency. drn_rdy → rdf_reg_data_rdy is a combinational path.
- word_cnt saturates at MAX_WORDS by construction: release happens on the handshake that reaches MAX_WORDS.

## Test plan
- Single TAG 3: 4 words A0..A3, last on A3, drn_rdy=1 → 4 consecutive handshakes with drn_tag=3. Done pulse one cycle after A3: tag=3, words=4, err=0.
- TAGs 0, 1, 2 valid simultaneously after reset, 2 words each → grant order 0, 1, 2, each exactly 2 words. Two idle cycles total between grants; done pulses for 0, 1, 2.
- Round-robin fairness: TAG 0 continuously re-requests while TAG 5 requests once after TAG 0's grant → TAG 5 is granted before TAG 0's second grant.
- Mid-grant stalls: drn_rdy toggles 1,0,1,0 and vld drops for 3 cycles on TAG 2 → no word is lost or repeated, and rdf_reg_data_rdy[2] mirrors drn_rdy. tag_en[2] cleared mid-grant → the grant completes; TAG 2 is then not re-granted while masked.
- Watchdog: MAX_WORDS=64, TAG 1 streams 70 words with no last → release after 64 handshakes. Done pulse: words=64, err=1. TAG 1 is re-granted later for the remaining 6 words.
- presetn asserted for 2 cycles mid-LOCK after 2 handshakes → outputs zero immediately and no done pulse. After reset, TAG 0 is first priority.
